// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding and bit-timing helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_front.sv
// RX line front end: synchroniser chain, start-edge detector and a 3-sample
// majority voter whose result is valid on the cycle after the second sample.
module uart_rx_front #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic sample,
    output logic fall,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   line;
    logic                   prev;
    logic [1:0]             samples;

    assign line = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            // Cleared rather than set: after reset the line has to be seen
            // high before a falling edge can start a frame.
            prev    <= 1'b0;
            samples <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // neighbour's pre-edge value, so the chain shifts one flop per clock.
            sync <= {sync[SYNC_STAGES-2:0], rx};
            prev <= line;
            if (sample) begin
                samples <= {samples[0], line};
            end
        end
    end

    assign fall = prev & ~line;
    assign vote = (samples[0] & samples[1]) | (samples[0] & line) | (samples[1] & line);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted bit sampling, configurable
// framing, one-cycle error pulses and a ready/valid output register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int HALF  = calc_half(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 2);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(DIV - 1);

    if (DIV < 8) begin : g_bad_div
        $error("uart_rx_param: CLK_FREQ/BAUD must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_param: SYNC_STAGES must be at least 2");
    end

    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 frame_flag;
    logic                 fall;
    logic                 vote;
    logic                 sample;
    logic                 at_half;
    logic                 at_end;
    logic                 done;
    logic                 frame_bad;
    logic                 par_bad;

    uart_rx_front #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_front (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .sample(sample),
        .fall  (fall),
        .vote  (vote)
    );

    assign at_half   = (cnt == CNT_HALF);
    assign at_end    = (cnt == CNT_END);
    assign sample    = (state != ST_IDLE) && (cnt == CNT_S0 || cnt == CNT_S1);
    // A frame finishes at the centre of its last stop bit so the next start
    // edge can be caught even when the sender runs slightly fast.
    assign done      = (state == ST_STOP) && at_half && (stop_idx == 1'(STOP_BITS - 1));
    assign frame_bad = frame_flag | ~vote;
    assign par_bad   = (PARITY == PAR_NONE) ? 1'b0 : (par_acc ^ (PARITY == PAR_ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns each output and no
        // latch is inferred.
        state_next = state;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START: begin
                if (at_half && vote) state_next = ST_IDLE;
                else if (at_end)     state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && bit_idx == 3'(DATA_BITS - 1)) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (at_end) state_next = ST_STOP;
            ST_STOP:   if (done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            frame_flag <= 1'b0;
        end else begin
            cnt <= (state == ST_IDLE || state_next != state || at_end) ? '0 : cnt + 1'b1;
            case (state)
                ST_START: begin
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    par_acc    <= 1'b0;
                    frame_flag <= 1'b0;
                end
                ST_DATA: begin
                    if (at_half) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ vote;
                    end
                    if (at_end) bit_idx <= bit_idx + 3'd1;
                end
                ST_PARITY: if (at_half) par_acc <= par_acc ^ vote;
                ST_STOP: begin
                    if (at_half && !vote) frame_flag <= 1'b1;
                    if (at_end) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data      <= '0;
            m_valid     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (m_ready) m_valid <= 1'b0;
            if (done) begin
                frame_err  <= frame_bad;
                parity_err <= par_bad;
                if (!frame_bad && !par_bad) begin
                    if (!m_valid || m_ready) begin
                        m_data  <= shreg;
                        m_valid <= 1'b1;
                    end else begin
                        overrun_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable clock/baud, data width, parity mode and stop-bit count.
- 3-sample majority vote at bit centre, false-start rejection, framing/parity/overrun error reporting.
- Ready/valid output register; sits between the board RX pin and the command/FIFO logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, payload bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
SYNC_STAGES, 2, metastability flops on rx, legal >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx  in  1  asynchronous serial input, idle high
m_data  out  DATA_BITS  received payload, LSB = first bit on the line
m_valid  out  1  m_data holds an unconsumed byte
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
frame_err  out  1  1-cycle pulse: a stop bit was sampled low
parity_err  out  1  1-cycle pulse: parity mismatch (PARITY != 0 only)
overrun_err  out  1  1-cycle pulse: good frame dropped because the output register was still full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: m_data = 0, m_valid = 0, all error pulses = 0, busy = 0, FSM = IDLE. Synchroniser flops reset to 1.
- Timing constants:
  - DIV = CLK_FREQ/BAUD (integer truncation); HALF = DIV/2.
  - Elaboration error if DIV < 8 or any parameter is outside its legal range.
- Bit-period counter cnt runs 0..DIV-1 in every non-IDLE state and restarts at 0 on each state/bit advance.
- Majority sampling:
  - Synchronised rx is sampled at cnt = HALF-2, HALF-1 and HALF.
  - Bit value = majority of the 3 samples, valid at cnt == HALF.
- Start detection: in IDLE, a synchronised 1->0 transition enters START with cnt = 0. A line held low (break) never retriggers until it returns high.
- FSM:
  - IDLE -> START on a falling edge.
  - START: at cnt == HALF, voted bit = 1 -> IDLE (glitch, no output, no error). Otherwise advance to DATA at cnt == DIV-1.
  - DATA: bit index 0..DATA_BITS-1, shift in LSB first at cnt == HALF. After the last bit at cnt == DIV-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: capture at cnt == HALF, then go to STOP at cnt == DIV-1.
    - Odd: the XOR of data bits and the parity bit must be 1.
    - Even: that XOR must be 0.
  - STOP: the stop-bit index counts STOP_BITS bits.
    - Each stop bit is checked at cnt == HALF; any low stop bit sets a sticky frame flag.
    - The frame completes at cnt == HALF of the last stop bit and the FSM returns to IDLE in the same cycle, without waiting out the bit. This permits back-to-back frames with tolerance for baud skew.
- Frame completion (the cycle after the completing sample):
  - Frame flag set -> frame_err = 1.
  - Parity mismatch -> parity_err = 1. Both may pulse together.
  - Any error -> payload discarded; m_valid and m_data unchanged.
  - No error, and (!m_valid or m_ready this cycle) -> m_data loaded, m_valid = 1.
  - No error, m_valid = 1 and !m_ready -> overrun_err = 1, new payload dropped, old m_data retained.
- m_valid clears the cycle after m_valid && m_ready, unless a new good frame completes that same cycle, in which case m_valid stays 1 with the new data.
- Latency: m_valid rises 1 clk after the HALF sample of the last stop bit.
- Reset mid-frame: immediate return to IDLE and all outputs reset. The remainder of the frame on the line is ignored until the next idle-high-to-low edge.

Decomposition:
- Shared package uart_pkg:
  - Parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - State encoding typedef (IDLE, START, DATA, PARITY, STOP).
  - Function computing DIV/HALF from CLK_FREQ/BAUD.
- One sub-module, uart_rx_front: synchroniser chain, falling-edge detect and 3-sample majority voter. Driven by the cnt strobes from the FSM.

Test Plan:
- Default params, send 0xA5 8N1 at DIV = 434 with m_ready = 1 -> m_valid pulses once, m_data = 0xA5, no errors, 1 clk after the stop-bit centre.
- DATA_BITS = 7, PARITY = 2: send 0x41 with parity 0, then 0x41 with parity 1 -> first gives m_data = 0x41; second gives parity_err, m_valid stays 0.
- rx low pulse of 150 clks, then high -> busy rises and falls, no m_valid, no errors. Also inject a single-clock high glitch in a data-bit centre -> majority vote yields the correct byte.
- Frame 0x3C with stop bit driven low, then rx held low for 20 bit times -> one frame_err pulse, no m_valid, no retrigger until rx returns high.
- m_ready = 0, send 0x11 then 0x22 -> m_data = 0x11 held, overrun_err pulses at the second frame end. Raise m_ready -> m_valid clears.
- STOP_BITS = 2, three back-to-back frames 0x00/0xFF/0x5A with ±2% baud skew -> all three received in order. Assert rst_n mid-second frame -> outputs reset, next clean frame received correctly.
